// File: rtl/lich_pkg.sv
// lich_pkg: shared mode enum, BCD constants and BCD helpers for the calendar counter
package lich_pkg;
   typedef enum logic [1:0] {CHAY, CHINH_NGAY, CHINH_THANG, CHINH_NAM} che_do_t;
   localparam logic [7:0] BCD_01 = 8'h01;
   localparam logic [7:0] BCD_12 = 8'h12;
   localparam logic [7:0] BCD_99 = 8'h99;
   function automatic logic [7:0] bcd_tang(input logic [7:0] x);
      return x == BCD_99 ? 8'h00 :
             x[3:0] == 4'd9 ? {x[7:4] + 4'd1, 4'd0} : {x[7:4], x[3:0] + 4'd1};
   endfunction
   // divisible by 4: even tens with units 0/4/8, odd tens with units 2/6
   function automatic logic la_nam_nhuan(input logic [7:0] x);
      return x[4] ? (x[3:0] == 4'd2 || x[3:0] == 4'd6) :
                    (x[3:0] == 4'd0 || x[3:0] == 4'd4 || x[3:0] == 4'd8);
   endfunction
endpackage

// File: rtl/ngay_toi_da.sv
// ngay_toi_da: number of days in a BCD month, given the leap-year flag
module ngay_toi_da (
   input  logic [7:0] thang,
   input  logic       nhuan,
   output logic [7:0] max_day
);
   always_comb
      max_day = thang == 8'h02 ? (nhuan ? 8'h29 : 8'h28) :
                (thang == 8'h04 || thang == 8'h06 || thang == 8'h09 || thang == 8'h11) ? 8'h30 : 8'h31;
endmodule

// File: rtl/dem_ngay_thang_nam.sv
// dem_ngay_thang_nam: BCD day/month/year calendar with a button-driven set mode.
// Macro CENTURY_EN adds the century register the_ky and the full Gregorian leap rule.
module dem_ngay_thang_nam
   import lich_pkg::*;
#(
   parameter logic [7:0] NGAY_RESET  = 8'h01,
   parameter logic [7:0] THANG_RESET = 8'h01,
   parameter logic [7:0] NAM_RESET   = 8'h00
`ifdef CENTURY_EN
   , parameter logic [7:0] THE_KY_RESET = 8'h20
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tang_ngay,
   input  logic       nut_chon,
   input  logic       nut_tang,
   output logic [7:0] ngay,
   output logic [7:0] thang,
   output logic [7:0] nam,
   output logic [1:0] che_do
`ifdef CENTURY_EN
   , output logic [7:0] the_ky
`endif
);
   che_do_t st;
   logic [7:0] thang_moi, nam_moi, max_day, max_moi;
   logic nhuan, nhuan_moi;
   assign che_do = st;
   // candidate month/year after a set-mode increment, used for the day clamp
   always_comb begin
      thang_moi = st == CHINH_THANG ? (thang == BCD_12 ? BCD_01 : bcd_tang(thang)) : thang;
      nam_moi   = st == CHINH_NAM ? bcd_tang(nam) : nam;
`ifdef CENTURY_EN
      nhuan     = la_nam_nhuan(nam == 8'h00 ? the_ky : nam);
      nhuan_moi = la_nam_nhuan(nam_moi == 8'h00 ? the_ky : nam_moi);
`else
      nhuan     = la_nam_nhuan(nam);
      nhuan_moi = la_nam_nhuan(nam_moi);
`endif
   end
   ngay_toi_da u_max     (.thang(thang),     .nhuan(nhuan),     .max_day(max_day));
   ngay_toi_da u_max_moi (.thang(thang_moi), .nhuan(nhuan_moi), .max_day(max_moi));
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st    <= CHAY;
         ngay  <= NGAY_RESET;
         thang <= THANG_RESET;
         nam   <= NAM_RESET;
`ifdef CENTURY_EN
         the_ky <= THE_KY_RESET;
`endif
      end else begin
         if (nut_chon)
            st <= che_do_t'(st + 2'd1);
         if (st == CHAY && tang_ngay) begin
            if (ngay < max_day)
               ngay <= bcd_tang(ngay);
            else begin
               ngay  <= BCD_01;
               thang <= thang == BCD_12 ? BCD_01 : bcd_tang(thang);
               if (thang == BCD_12) begin
                  nam <= bcd_tang(nam);
`ifdef CENTURY_EN
                  if (nam == BCD_99)
                     the_ky <= bcd_tang(the_ky);
`endif
               end
            end
         end else if (st != CHAY && nut_tang && !nut_chon) begin
            if (st == CHINH_NGAY)
               ngay <= ngay >= max_day ? BCD_01 : bcd_tang(ngay);
            else begin
               thang <= thang_moi;
               nam   <= nam_moi;
               ngay  <= ngay > max_moi ? max_moi : ngay;
            end
         end
      end
endmodule

// File: tb/tb_dem_ngay_thang_nam.sv
// tb_dem_ngay_thang_nam: directed and random checks against an integer calendar model
module tb_dem_ngay_thang_nam;
   logic clk = 0, rst = 1, tang_ngay = 0, nut_chon = 0, nut_tang = 0;
   logic [7:0] ngay, thang, nam;
   logic [1:0] che_do;
`ifdef CENTURY_EN
   logic [7:0] the_ky;
`endif
   int n_pass = 0, n_tot = 0;
   int md = 1, mm = 1, my = 0, mc = 20, mmode = 0;

   dem_ngay_thang_nam dut (
      .clk(clk), .rst(rst), .tang_ngay(tang_ngay), .nut_chon(nut_chon), .nut_tang(nut_tang),
      .ngay(ngay), .thang(thang), .nam(nam), .che_do(che_do)
`ifdef CENTURY_EN
      , .the_ky(the_ky)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] bcd(input int n);
      return 8'((n / 10) * 16 + n % 10);
   endfunction

   function automatic bit m_leap(input int y);
`ifdef CENTURY_EN
      int f = mc * 100 + y;
      return (f % 4 == 0 && f % 100 != 0) || f % 400 == 0;
`else
      return y % 4 == 0;
`endif
   endfunction

   function automatic int m_max(input int m, input int y);
      if (m == 2) return m_leap(y) ? 29 : 28;
      return (m == 4 || m == 6 || m == 9 || m == 11) ? 30 : 31;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic compare();
      chk("ngay", ngay, bcd(md));
      chk("thang", thang, bcd(mm));
      chk("nam", nam, bcd(my));
      chk("che_do", {6'd0, che_do}, bcd(mmode));
`ifdef CENTURY_EN
      chk("the_ky", the_ky, bcd(mc));
`endif
   endtask

   task automatic m_update(input bit c, input bit t, input bit k);
      if (mmode == 0 && k) begin
         if (md < m_max(mm, my)) md++;
         else begin
            md = 1;
            if (mm < 12) mm++;
            else begin
               mm = 1;
               if (my < 99) my++;
               else begin
                  my = 0;
                  mc = (mc + 1) % 100;
               end
            end
         end
      end else if (mmode != 0 && t && !c) begin
         if (mmode == 1) md = md >= m_max(mm, my) ? 1 : md + 1;
         else begin
            if (mmode == 2) mm = mm % 12 + 1;
            else my = (my + 1) % 100;
            if (md > m_max(mm, my)) md = m_max(mm, my);
         end
      end
      if (c) mmode = (mmode + 1) % 4;
   endtask

   task automatic step(input bit c, input bit t, input bit k);
      @(negedge clk);
      nut_chon = c;
      nut_tang = t;
      tang_ngay = k;
      @(posedge clk);
      #1;
      nut_chon = 0;
      nut_tang = 0;
      tang_ngay = 0;
      m_update(c, t, k);
      compare();
   endtask

   // day goes to 01 first so month/year edits never clamp, then to the target
   task automatic set_date(input int d, input int m, input int y);
      while (mmode != 0) step(1, 0, 0);
      step(1, 0, 0);
      while (md != 1) step(0, 1, 0);
      step(1, 0, 0);
      while (mm != m) step(0, 1, 0);
      step(1, 0, 0);
      while (my != y) step(0, 1, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      while (md != d) step(0, 1, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 0, 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      compare();
      chk("rst_ngay", ngay, 8'h01);
      chk("rst_thang", thang, 8'h01);
      chk("rst_nam", nam, 8'h00);
      chk("rst_che_do", {6'd0, che_do}, 8'h00);
`ifdef CENTURY_EN
      chk("rst_the_ky", the_ky, 8'h20);
`endif
      rst = 0;

      set_date(28, 2, 23);
      step(0, 0, 1);
      chk("feb23_ngay", ngay, 8'h01);
      chk("feb23_thang", thang, 8'h03);
      set_date(28, 2, 24);
      step(0, 0, 1);
      chk("feb24_29", ngay, 8'h29);
      step(0, 0, 1);
      chk("feb24_ngay", ngay, 8'h01);
      chk("feb24_thang", thang, 8'h03);

      set_date(30, 4, 57);
      step(0, 0, 1);
      chk("apr_ngay", ngay, 8'h01);
      chk("apr_thang", thang, 8'h05);
      set_date(31, 12, 99);
      step(0, 0, 1);
      chk("nye_ngay", ngay, 8'h01);
      chk("nye_thang", thang, 8'h01);
      chk("nye_nam", nam, 8'h00);
`ifdef CENTURY_EN
      chk("nye_the_ky", the_ky, 8'h21);
`endif

      set_date(31, 1, 23);
      step(1, 0, 0);
      step(1, 0, 0);
      step(0, 1, 0);
      chk("clamp_ngay", ngay, 8'h28);
      chk("clamp_thang", thang, 8'h02);
      step(0, 0, 1);
      chk("set_tick", ngay, 8'h28);

      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 1, 0);
      chk("both_mode", {6'd0, che_do}, 8'h02);
      chk("both_ngay", ngay, 8'h28);
      step(1, 0, 0);
      @(negedge clk);
      #2 rst = 1;
      #1;
      md = 1; mm = 1; my = 0; mc = 20; mmode = 0;
      compare();
      chk("midrst_che_do", {6'd0, che_do}, 8'h00);
      @(negedge clk);
      rst = 0;

`ifdef CENTURY_EN
      while (mc != 19) begin
         set_date(31, 12, 99);
         step(0, 0, 1);
      end
      set_date(28, 2, 0);
      step(0, 0, 1);
      chk("c19_ngay", ngay, 8'h01);
      chk("c19_thang", thang, 8'h03);
      set_date(31, 12, 99);
      step(0, 0, 1);
      chk("c20_the_ky", the_ky, 8'h20);
      set_date(28, 2, 0);
      step(0, 0, 1);
      chk("c20_ngay", ngay, 8'h29);
      chk("c20_thang", thang, 8'h02);
`endif

      for (int i = 0; i < 3000; i++) begin
         int r = int'($urandom_range(0, 99));
         step(r < 6, r >= 40, $urandom_range(0, 2) != 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
